// File: rtl/player_motion.sv
// rtl/player_motion.sv - frame-synchronous walk/jump/clamp/separation engine for two fighters
module player_motion #(
    parameter int NUM_KEYS   = 4,
    parameter int GROUND_Y   = 400,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 640,
    parameter int PLAYER_W   = 64,
    parameter int WALK_STEP  = 2,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int P1_START_X = 160,
    parameter int P2_START_X = 480,
    parameter logic [7:0] P1_LEFT  = 8'h04,
    parameter logic [7:0] P1_RIGHT = 8'h07,
    parameter logic [7:0] P1_JUMP  = 8'h1A,
    parameter logic [7:0] P2_LEFT  = 8'h50,
    parameter logic [7:0] P2_RIGHT = 8'h4F,
    parameter logic [7:0] P2_JUMP  = 8'h52
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic [8*NUM_KEYS-1:0]   keycodes,
    output logic [9:0]              Player1X,
    output logic [9:0]              Player1Y,
    output logic [9:0]              Player2X,
    output logic [9:0]              Player2Y,
    output logic                    p1_airborne,
    output logic                    p2_airborne,
    output logic                    frame_tick
);
    typedef enum logic {GROUND, AIR} state_t;

    localparam logic signed [10:0] XL = 11'(X_MIN);
    localparam logic signed [10:0] XR = 11'(X_MAX - PLAYER_W);
    localparam logic signed [10:0] PW = 11'(PLAYER_W);
    localparam logic signed [10:0] WS = 11'(WALK_STEP);
    localparam logic signed [11:0] GY = 12'(GROUND_Y);

    function automatic logic key_held(input logic [8*NUM_KEYS-1:0] kc, input logic [7:0] code);
        key_held = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (code != 8'h00 && kc[8*i +: 8] == code)
                key_held = 1'b1;
    endfunction

    logic s0, s1, s2, tick;
    assign tick = s1 & ~s2;

    state_t             st     [2];
    logic [9:0]         px     [2];
    logic [9:0]         py     [2];
    logic signed [11:0] vy     [2];
    logic signed [10:0] air_dx [2];
    logic               armed  [2];

    state_t             n_st     [2];
    logic signed [10:0] n_x      [2];
    logic signed [10:0] cand     [2];
    logic signed [10:0] adx      [2];
    logic signed [10:0] dx       [2];
    logic [9:0]         n_py     [2];
    logic signed [11:0] n_vy     [2];
    logic signed [10:0] n_air_dx [2];
    logic               n_armed  [2];

    always_comb begin
        logic l, r, j, tw0, tw1;
        logic signed [11:0] ny;
        for (int p = 0; p < 2; p++) begin
            l = key_held(keycodes, p == 0 ? P1_LEFT  : P2_LEFT);
            r = key_held(keycodes, p == 0 ? P1_RIGHT : P2_RIGHT);
            j = key_held(keycodes, p == 0 ? P1_JUMP  : P2_JUMP);
            dx[p] = (r && !l) ? WS : (l && !r) ? -WS : 11'sd0;
            adx[p] = (st[p] == AIR) ? air_dx[p] : dx[p];
            cand[p] = $signed({1'b0, px[p]}) + adx[p];
            if (cand[p] < XL)
                cand[p] = XL;
            else if (cand[p] > XR)
                cand[p] = XR;

            n_st[p]     = st[p];
            n_py[p]     = py[p];
            n_vy[p]     = vy[p];
            n_air_dx[p] = air_dx[p];
            n_armed[p]  = armed[p] | ~j;
            ny          = $signed({2'b00, py[p]}) + vy[p];
            if (st[p] == GROUND) begin
                if (j && armed[p]) begin
                    n_st[p]     = AIR;
                    n_vy[p]     = -12'(JUMP_VEL);
                    n_air_dx[p] = dx[p];
                    n_armed[p]  = 1'b0;
                end
            end else begin
                n_vy[p] = vy[p] + 12'(GRAVITY);
                if (ny >= GY) begin
                    n_py[p] = 10'(GROUND_Y);
                    n_vy[p] = 12'sd0;
                    n_st[p] = GROUND;
                end else if (ny < 0) begin
                    n_py[p] = 10'd0;
                end else begin
                    n_py[p] = 10'(ny);
                end
            end
        end

        // Only the player pushing into the gap is held back; with no culprit both stay put.
        n_x[0] = cand[0];
        n_x[1] = cand[1];
        tw0 = adx[0] > 0;
        tw1 = adx[1] < 0;
        if (cand[1] - cand[0] < PW) begin
            if ((!tw0 && !tw1) || tw0) n_x[0] = $signed({1'b0, px[0]});
            if ((!tw0 && !tw1) || tw1) n_x[1] = $signed({1'b0, px[1]});
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
            frame_tick <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                st[p]     <= GROUND;
                px[p]     <= (p == 0) ? 10'(P1_START_X) : 10'(P2_START_X);
                py[p]     <= 10'(GROUND_Y);
                vy[p]     <= 12'sd0;
                air_dx[p] <= 11'sd0;
                armed[p]  <= 1'b1;
            end
        end else begin
            s0 <= frame_clk;
            s1 <= s0;
            s2 <= s1;
            frame_tick <= tick;
            if (tick) begin
                for (int p = 0; p < 2; p++) begin
                    st[p]     <= n_st[p];
                    px[p]     <= 10'(n_x[p]);
                    py[p]     <= n_py[p];
                    vy[p]     <= n_vy[p];
                    air_dx[p] <= n_air_dx[p];
                    armed[p]  <= n_armed[p];
                end
            end
        end
    end

    assign Player1X    = px[0];
    assign Player1Y    = py[0];
    assign Player2X    = px[1];
    assign Player2Y    = py[1];
    assign p1_airborne = (st[0] == AIR);
    assign p2_airborne = (st[1] == AIR);
endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - directed self-checking bench for player_motion
module tb_player_motion;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [31:0] keycodes = 32'h0;
    logic [9:0]  Player1X, Player1Y, Player2X, Player2Y;
    logic        p1_airborne, p2_airborne, frame_tick;

    int n_checks = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    player_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycodes(keycodes),
        .Player1X(Player1X), .Player1Y(Player1Y), .Player2X(Player2X), .Player2Y(Player2Y),
        .p1_airborne(p1_airborne), .p2_airborne(p2_airborne), .frame_tick(frame_tick)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk)
        if (frame_tick) tick_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (4) @(negedge Clk);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        keycodes = 32'h0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_p1x", Player1X, 160);
        chk("rst_p1y", Player1Y, 400);
        chk("rst_p2x", Player2X, 480);
        chk("rst_p2y", Player2Y, 400);
        chk("rst_air", {p1_airborne, p2_airborne}, 0);
        chk("rst_tick", frame_tick, 0);
        Reset = 1'b0;

        frames(3);
        chk("idle_p1x", Player1X, 160);
        chk("idle_p2x", Player2X, 480);
        chk("idle_ticks", tick_cnt, 3);

        // walk right from slot3, first frame checked for update latency
        keycodes = 32'h0700_0000;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        chk("lat_before_x", Player1X, 160);
        chk("lat_before_tick", frame_tick, 0);
        @(negedge Clk);
        chk("lat_after_x", Player1X, 162);
        chk("lat_after_tick", frame_tick, 1);
        @(negedge Clk);
        chk("lat_tick_pulse", frame_tick, 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        frames(7);
        chk("walk8_p1x", Player1X, 176);
        keycodes = 32'h0700_0004;
        frames(5);
        chk("both_dir_p1x", Player1X, 176);
        chk("walk_ticks", tick_cnt, 16);

        // jump arc
        keycodes = 32'h0000_001A;
        frames(1);
        chk("takeoff_air", p1_airborne, 1);
        chk("takeoff_y", Player1Y, 400);
        keycodes = 32'h0;
        frames(1);
        chk("k1_y", Player1Y, 388);
        frames(22);
        chk("k23_y", Player1Y, 377);
        frames(1);
        chk("k24_y", Player1Y, 388);
        chk("k24_air", p1_airborne, 1);
        frames(1);
        chk("k25_y", Player1Y, 400);
        chk("k25_air", p1_airborne, 0);
        chk("jump_p1x", Player1X, 176);

        // held jump key: one jump, no auto-repeat
        keycodes = 32'h001A_0000;
        frames(26);
        chk("held_land_air", p1_airborne, 0);
        frames(4);
        chk("held_norepeat_air", p1_airborne, 0);
        chk("held_norepeat_y", Player1Y, 400);

        // air control: take-off with right, then live left is ignored
        keycodes = 32'h0;
        frames(1);
        keycodes = 32'h0007_1A00;
        frames(1);
        chk("ac_takeoff_x", Player1X, 178);
        keycodes = 32'h0000_0004;
        frames(10);
        chk("ac_mid_x", Player1X, 198);
        frames(15);
        chk("ac_land_x", Player1X, 228);
        chk("ac_land_air", p1_airborne, 0);
        frames(1);
        chk("ac_ground_x", Player1X, 226);

        // reset mid-jump
        keycodes = 32'h0000_5200;
        frames(3);
        chk("p2_jump_air", p2_airborne, 1);
        chk("p2_jump_y", Player2Y, 377);
        #3 Reset = 1'b1;
        #1;
        chk("midrst_p1x", Player1X, 160);
        chk("midrst_p2y", Player2Y, 400);
        chk("midrst_air", p2_airborne, 0);
        keycodes = 32'h0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // collision
        keycodes = 32'h0000_5000;
        frames(128);
        chk("col_p2x_128", Player2X, 224);
        frames(2);
        chk("col_p2x_hold", Player2X, 224);
        keycodes = 32'h0050_0007;
        frames(3);
        chk("col_both_p1x", Player1X, 160);
        chk("col_both_p2x", Player2X, 224);

        // clamps on both arena edges
        do_reset();
        keycodes = 32'h4F00_0004;
        frames(79);
        chk("clamp79_p1x", Player1X, 2);
        chk("clamp79_p2x", Player2X, 576);
        frames(21);
        chk("clamp100_p1x", Player1X, 0);
        chk("clamp100_p2x", Player2X, 576);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Frame-synchronous motion engine for the two fighters. Replaces the fixed-step player controller with a parametrised block that adds gravity jumps, arena clamping and a no-overlap rule between fighters.
- Decodes up to NUM_KEYS concurrent USB keycodes and updates both positions once per VGA frame.
- Outputs feed the color mapper directly.

Parameters:
- NUM_KEYS, 4, number of 8-bit keycode slots in keycodes.
- GROUND_Y, 400, Y of a standing fighter.
- X_MIN, 0, leftmost legal X.
- X_MAX, 640, right arena edge; legal X ≤ X_MAX-PLAYER_W.
- PLAYER_W, 64, fighter width; also the minimum X separation.
- WALK_STEP, 2, pixels per frame of horizontal motion.
- JUMP_VEL, 12, initial upward speed in px/frame.
- GRAVITY, 1, per-frame vertical speed increment.
- P1_START_X, 160, reset X of player 1.
- P2_START_X, 480, reset X of player 2.
- P1_LEFT / P1_RIGHT / P1_JUMP, 8'h04 / 8'h07 / 8'h1A, player 1 key codes (A/D/W).
- P2_LEFT / P2_RIGHT / P2_JUMP, 8'h50 / 8'h4F / 8'h52, player 2 key codes (arrows).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  VGA vsync level; asynchronous to Clk.
- keycodes  in  8*NUM_KEYS  slot i occupies bits [8i+7:8i].
- Player1X, Player1Y, Player2X, Player2Y  out  10 each  top-left of each fighter.
- p1_airborne, p2_airborne  out  1 each  high while jumping.
- frame_tick  out  1  one-Clk pulse marking a position update.

Behaviour:
- Reset (async): PnX = Pn_START_X; PnY = GROUND_Y; airborne = 0; vy = 0; jump_armed = 1; frame_tick = 0; sync flops cleared.
- Frame tick:
  - frame_clk passes through 3 flops s0, s1, s2; tick = s1 & ~s2.
  - All state commits on the Clk edge where tick = 1. frame_clk high → new outputs after the 3rd Clk edge. frame_tick is registered tick, coincident with the output update.
  - Exactly one update per frame_clk rising edge.
- Key decode: a key is held if any slot equals its code. 8'h00 never matches. Duplicate codes across slots are harmless.
- Horizontal intent dx per player:
  - right & ~left → +WALK_STEP.
  - left & ~right → -WALK_STEP.
  - both or neither → 0.
- Per-player FSM:
  - GROUND: x += dx. If jump held and jump_armed: go to AIR, vy = -JUMP_VEL, latch air_dx = dx, jump_armed = 0, airborne = 1.
  - AIR: x += air_dx (live keys ignored horizontally). ny = y + vy (signed 12-bit), then vy += GRAVITY.
    - If ny ≥ GROUND_Y: y = GROUND_Y, vy = 0, go to GROUND, airborne = 0.
    - Else if ny < 0: y = 0.
    - Else y = ny.
  - The y applied on the take-off frame is unchanged; the first rise occurs on the next tick.
  - jump_armed is set on any tick where the jump key is not held, in either state. A held key never auto-repeats.
- Horizontal clamp: the candidate x is clamped to [X_MIN, X_MAX-PLAYER_W] using signed 11-bit arithmetic, so no wrap below 0.
- Separation (P1 always left of P2):
  - Check after clamping. If cand P2X - cand P1X < PLAYER_W, revert to the old X every player whose applied dx moved toward the other (P1 dx>0, P2 dx<0).
  - If neither moved toward the other (for example, clamp-induced), revert both.
  - Players never cross. Airborne players obey the same rule.
- Simultaneous events:
  - A landing tick and a new jump press: the jump is taken on the next tick.
  - Reset mid-jump returns immediately to reset values.

Test Plan:
- Reset: assert Reset → P1=(160,400), P2=(480,400), airborne=0. Release with frame_clk toggling and no keys → values hold; frame_tick pulses once per frame.
- Walk: keycodes slot3=8'h07 for 8 frames → Player1X=176; add 8'h04 in slot0 for 5 frames → Player1X stays 176.
- Jump arc:
  - Press 8'h1A for 1 frame, then release → airborne=1.
  - After tick k from take-off: Player1Y = 400-12k+k(k-1)/2, so k=1→388 and k=24→388.
  - k=25 → Player1Y=400, airborne=0.
  - Holding 8'h1A continuously gives exactly one jump.
- Air control: press 8'h07 with 8'h1A, then switch to 8'h04 mid-air → X keeps increasing by +2 per frame until landing.
- Collision: hold 8'h50 only → P2X falls by 2 per frame to 224 after 128 frames, then holds at 224. Add P1 8'h07 → both X frozen (P1 176 is not reached; P1X stays 160).
- Clamp and reset: hold 8'h04 100 frames → Player1X=0 from frame 80 onward. Assert Reset mid-jump → immediate reset values.
